// File: rtl/uart_rx_mon.sv
// Tester-side 8N1 UART receiver that monitors the DUT's uart_tx pin and
// queues received bytes in a small first-word-fall-through FIFO.
module uart_rx_mon #(
    parameter int CLKS_PER_BIT = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       s_clk,
    input  logic       rst_n,
    input  logic       uart_tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       clr_err,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    logic sync1, rxs, rxs_prev;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, pop, push, frame_set, do_push, ovf_set, stop_hit;

    // Synchronizer and edge-detect flops reset to the idle-line level so a
    // line held low across reset release cannot fake a start edge.
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbour.
            sync1    <= uart_tx;
            rxs      <= sync1;
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rxs_prev && !rxs) begin
                        cnt   <= HALF_BIT;
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt     <= FULL_BIT;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift_reg <= {rxs, shift_reg[7:1]};
                        cnt       <= FULL_BIT;
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The FIFO is written on the stop-sample edge itself, so the byte is
    // visible the following cycle.
    assign stop_hit  = (state == STOP) && (cnt == '0);
    assign push      = stop_hit && rxs;
    assign frame_set = stop_hit && !rxs;

    assign rx_valid = (wr_ptr != rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = rx_valid && rx_ready;
    assign do_push  = push && (!full || pop);
    assign ovf_set  = push && full && !pop;

    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; an empty FIFO presents 0x00
    // through the output gate below, so stale entries are never observable.
    always_ff @(posedge s_clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= shift_reg;
    end

    assign rx_data = rx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    // Sticky flags: a set in the same cycle as clr_err wins.
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (frame_set)
                frame_err <= 1'b1;
            else if (clr_err)
                frame_err <= 1'b0;
            if (ovf_set)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_mon.sv
// Directed bench for uart_rx_mon: serial frames are generated bit by bit and
// FIFO/flag behaviour is compared against hand-computed values.
module tb_uart_rx_mon;

    logic       s_clk;
    logic       rst_n;
    logic       uart_tx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       clr_err;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_rx_mon #(.CLKS_PER_BIT(32), .FIFO_DEPTH(4)) dut (
        .s_clk    (s_clk),
        .rst_n    (rst_n),
        .uart_tx  (uart_tx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .clr_err  (clr_err),
        .frame_err(frame_err),
        .overflow (overflow),
        .busy     (busy)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every task leaves time at 1 ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge s_clk);
            #1;
        end
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    // One 320-cycle frame. pop_at >= 0 raises rx_ready for the single cycle
    // ending on edge pop_at+1; lat_chk probes rx_valid around the stop sample.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                             input int pop_at, input logic lat_chk);
        logic [7:0] bits;
        bits = b;
        for (int c = 0; c < 320; c++) begin
            if (c < 32)
                uart_tx = 1'b0;
            else if (c < 288)
                uart_tx = bits[(c - 32) / 32];
            else
                uart_tx = stop_bit;
            if (pop_at >= 0)
                rx_ready = (c == pop_at);
            if (lat_chk && c == 306)
                check("latency_before", rx_valid, 1'b0);
            if (lat_chk && c == 307)
                check("latency_after", rx_valid, 1'b1);
            tick(1);
        end
        if (pop_at >= 0)
            rx_ready = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        uart_tx  = 1'b1;
        rx_ready = 1'b0;
        clr_err  = 1'b0;
        #1;
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", rx_data, 8'h00);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_busy", busy, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(10);

        // Two bytes, no consumer.
        send_byte(8'h55, 1'b1, -1, 1'b1);
        send_byte(8'hA3, 1'b1, -1, 1'b0);
        check("two_valid", rx_valid, 1'b1);
        check("two_head", rx_data, 8'h55);
        pop_one();
        check("two_second", rx_data, 8'hA3);
        check("two_valid2", rx_valid, 1'b1);
        pop_one();
        check("two_empty", rx_valid, 1'b0);
        check("two_ferr", frame_err, 1'b0);
        check("two_ovf", overflow, 1'b0);

        // 10-cycle low glitch.
        uart_tx = 1'b0;
        tick(10);
        check("glitch_busy", busy, 1'b1);
        uart_tx = 1'b1;
        tick(20);
        check("glitch_idle", busy, 1'b0);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_ferr", frame_err, 1'b0);
        tick(20);

        // Framing error followed by a break, then a good byte.
        send_byte(8'h3C, 1'b0, -1, 1'b0);
        uart_tx = 1'b0;
        tick(96);
        check("ferr_set", frame_err, 1'b1);
        check("ferr_wait_busy", busy, 1'b1);
        check("ferr_not_stored", rx_valid, 1'b0);
        uart_tx = 1'b1;
        tick(10);
        check("ferr_idle", busy, 1'b0);
        tick(22);
        send_byte(8'h81, 1'b1, -1, 1'b0);
        check("after_ferr_valid", rx_valid, 1'b1);
        check("after_ferr_data", rx_data, 8'h81);
        check("ferr_sticky", frame_err, 1'b1);
        pop_one();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("ferr_cleared", frame_err, 1'b0);
        check("clr_fifo_empty", rx_valid, 1'b0);

        // Five bytes into a depth-4 FIFO.
        for (int i = 1; i <= 5; i++)
            send_byte(8'(i), 1'b1, -1, 1'b0);
        check("ovf_set", overflow, 1'b1);
        check("ovf_ferr", frame_err, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", rx_valid, 1'b1);
            check("drain_data", rx_data, 8'(i));
            rx_ready = 1'b1;
            tick(1);
        end
        rx_ready = 1'b0;
        check("drain_empty", rx_valid, 1'b0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Full FIFO with a pop coinciding with the push of 0x99.
        send_byte(8'h11, 1'b1, -1, 1'b0);
        send_byte(8'h22, 1'b1, -1, 1'b0);
        send_byte(8'h33, 1'b1, -1, 1'b0);
        send_byte(8'h44, 1'b1, -1, 1'b0);
        check("full_head", rx_data, 8'h11);
        send_byte(8'h99, 1'b1, 306, 1'b0);
        check("simul_no_ovf", overflow, 1'b0);
        check("simul_head", rx_data, 8'h22);
        pop_one();
        check("simul_d1", rx_data, 8'h33);
        pop_one();
        check("simul_d2", rx_data, 8'h44);
        pop_one();
        check("simul_last", rx_data, 8'h99);
        pop_one();
        check("simul_empty", rx_valid, 1'b0);

        // Reset midway through data bit 4 of 0xF0.
        uart_tx = 1'b0;
        tick(160);
        uart_tx = 1'b1;
        tick(16);
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_valid", rx_valid, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(40);
        check("post_rst_busy", busy, 1'b0);
        send_byte(8'h0F, 1'b1, -1, 1'b0);
        check("post_rst_valid", rx_valid, 1'b1);
        check("post_rst_data", rx_data, 8'h0F);
        pop_one();
        check("post_rst_only", rx_valid, 1'b0);
        check("post_rst_ferr", frame_err, 1'b0);
        check("post_rst_ovf", overflow, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_mon.md
Name: uart_rx_mon

Overview:
- Tester-side UART receiver for the FPGA chip-test harness; samples the pulpino `uart_tx` pin (8N1, LSB first).
- Buffers received bytes in a small first-word-fall-through FIFO so harness logic can read console output (e.g. test pass/fail strings) after the fetch phase.
- Counterpart to the harness's outbound stimulus paths: it observes the DUT, never drives it.

Parameters:
- CLKS_PER_BIT, 32, `s_clk` cycles per UART bit (25 MHz / 781250 baud); must be ≥ 8.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥ 2.

Ports:
- s_clk  input  1  system clock, 25 MHz.
- rst_n  input  1  asynchronous active-low reset.
- uart_tx  input  1  serial line from the DUT; asynchronous to `s_clk`, idle high.
- rx_data  output  8  FIFO head byte; valid only while `rx_valid` = 1.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer pops the head when `rx_valid` && `rx_ready` at a rising edge.
- clr_err  input  1  one-cycle pulse clears `frame_err` and `overflow`.
- frame_err  output  1  sticky; a stop bit was sampled low.
- overflow  output  1  sticky; a good byte was dropped because the FIFO was full.
- busy  output  1  receiver FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; FIFO empty; `rx_valid` = 0; `rx_data` = 0x00; `frame_err` = 0; `overflow` = 0; `busy` = 0.
  - Both synchronizer flops reset to 1.
- Input synchronization:
  - `uart_tx` passes through a 2-flop synchronizer; all decisions use the synchronized value `rxs`.
  - A previous-value flop provides falling-edge detection.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on a falling edge of `rxs`, load the bit counter with CLKS_PER_BIT/2 − 1 and go to START.
  - START: at counter = 0, sample `rxs`.
    - If 1 (glitch), return to IDLE; nothing is recorded.
    - If 0, load CLKS_PER_BIT − 1, clear the bit index, go to DATA.
  - DATA: at each counter = 0, shift `rxs` into the shift register MSB (right shift; LSB arrives first) and reload CLKS_PER_BIT − 1.
    - After the 8th sample, go to STOP.
  - STOP: at counter = 0, sample `rxs`.
    - If 1: issue a push request and go to IDLE.
    - If 0: set `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs` = 1, then go to IDLE. This prevents a break condition from being taken as a new start bit.
- Sampling: each bit is sampled once at its midpoint (CLKS_PER_BIT/2 after the start edge, then every CLKS_PER_BIT).
- Latency: the byte is visible on `rx_data`/`rx_valid` on the cycle after the stop-bit sample edge when the FIFO was empty.
- FIFO:
  - First-word fall-through; `rx_data` is always the head entry.
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Push when full without a simultaneous pop: the byte is dropped, `overflow` is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both occur; count unchanged; no overflow.
  - Push and pop in the same cycle while count = 1: head advances to the new byte; `rx_valid` stays 1.
  - Pop while empty: ignored.
- Sticky flags:
  - Set and clear in the same cycle: set wins.
  - `clr_err` does not affect the FIFO or the FSM.
- `busy` = 1 in START, DATA, STOP and WAIT_IDLE.
- Reset mid-frame: all state is cleared immediately. After release, a line still low does not start reception until `rxs` has been seen high and then falls, since the previous-value flop resets to 1 and the edge detector needs a 1→0 transition.

Test Plan:
- Send 0x55 then 0xA3 at 32 clk/bit, `rx_ready` = 0 → `rx_valid` = 1 with `rx_data` = 0x55; pop → `rx_data` = 0xA3; pop → `rx_valid` = 0; both flags = 0.
- Low glitch on `uart_tx` of 10 cycles (< 16) → FSM returns to IDLE, `busy` drops, FIFO stays empty, no flags set.
- Frame 0x3C with the stop bit driven low, line held low for 3 bit times, then 0x81 sent normally:
  - `frame_err` = 1 and 0x3C is not stored.
  - 0x81 is received correctly.
  - `clr_err` pulse → `frame_err` = 0.
- Send 5 bytes 0x01–0x05 with `rx_ready` = 0 (depth 4) → FIFO holds 0x01–0x04 and `overflow` = 1. Drain with `rx_ready` = 1 → data reads 0x01, 0x02, 0x03, 0x04, then `rx_valid` = 0.
- FIFO full with `rx_ready` asserted exactly on the push cycle of 0x99 → no overflow; subsequent reads end with 0x99.
- Assert `rst_n` low midway through data bit 4 of 0xF0, release while the line is high, send 0x0F → only 0x0F appears; `busy` = 0 during reset.
